// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with trap and retire counter
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      INST,
    input  logic             ZERO,
    input  logic             MEM_READY,
    output logic             PC_WE,
    output logic             PC_SRC,
    output logic             IR_WE,
    output logic             MEM_RE,
    output logic             MEM_WE,
    output logic             RF_WE,
    output logic             WB_SEL,
    output logic             ALU_SRCA,
    output logic [1:0]       ALU_SRCB,
    output logic [3:0]       ALU_CTRL,
    output logic [2:0]       STATE,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] INSTRET
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] SRCB_RD2   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;

    state_e             state_q, state_d;
    logic               illegal_q;
    logic [CNT_W-1:0]   instret_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       is_r, is_i, is_load, is_store, is_beq;
    logic       r_funct7_ok, legal;
    logic       unused_inst_bits;

    assign opcode = INST[6:0];
    assign rd     = INST[11:7];
    assign funct3 = INST[14:12];
    assign funct7 = INST[31:25];
    assign unused_inst_bits = ^INST[24:15];

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_beq   = (opcode == OP_BRANCH) && (funct3 == 3'b000);

    // Only SUB and SRA may use the alternate funct7 encoding
    assign r_funct7_ok = (funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    assign legal = (is_r && r_funct7_ok) || is_i || is_load || is_store || is_beq;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic       pc_we, ir_we, mem_re, mem_we, rf_we;
    logic       pc_src, wb_sel, alu_srca;
    logic [1:0] alu_srcb;
    logic [3:0] alu_ctrl;
    logic       retire, trap_set;

    always_comb begin
        state_d  = state_q;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        ir_we    = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        alu_srca = 1'b0;
        alu_srcb = SRCB_RD2;
        alu_ctrl = ALU_ADD;
        retire   = 1'b0;
        trap_set = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_re   = 1'b1;
                alu_srcb = SRCB_FOUR;
                if (MEM_READY) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d  = S_TRAP;
                    trap_set = 1'b1;
                end
            end
            S_EXEC: begin
                alu_srca = 1'b1;
                if (is_r) begin
                    alu_ctrl = alu_op(funct3, INST[30]);
                    state_d  = S_WB;
                end else if (is_i) begin
                    // ADDI has no subtract form; only the shift-right slot uses INST[30]
                    alu_srcb = SRCB_IMM;
                    alu_ctrl = alu_op(funct3, (funct3 == 3'b101) && INST[30]);
                    state_d  = S_WB;
                end else if (is_load || is_store) begin
                    alu_srcb = SRCB_IMM;
                    state_d  = S_MEM;
                end else if (is_beq) begin
                    alu_ctrl = ALU_SUB;
                    pc_we    = ZERO;
                    pc_src   = ZERO;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_TRAP;
                    trap_set = 1'b1;
                end
            end
            S_MEM: begin
                if (is_store) begin
                    mem_we = 1'b1;
                    if (MEM_READY) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    mem_re = 1'b1;
                    if (MEM_READY) begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = (rd != 5'd0);
                wb_sel  = is_load;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (trap_set) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    // Enables are masked during reset so no write lands in the reset cycle
    assign PC_WE    = pc_we  & ~RST;
    assign IR_WE    = ir_we  & ~RST;
    assign MEM_RE   = mem_re & ~RST;
    assign MEM_WE   = mem_we & ~RST;
    assign RF_WE    = rf_we  & ~RST;
    assign PC_SRC   = pc_src;
    assign WB_SEL   = wb_sel;
    assign ALU_SRCA = alu_srca;
    assign ALU_SRCB = alu_srcb;
    assign ALU_CTRL = alu_ctrl;
    assign STATE    = state_q;
    assign ILLEGAL  = illegal_q;
    assign INSTRET  = instret_q;

endmodule
